// File: rtl/cap_sense_scanner.sv
// Round-robin capacitive pad scanner. One drive pin and one counter are shared by all pads.
// Each pad's RC rise time is measured and the touch decision is debounced across whole scans.
//
// state     | meaning
// IDLE      | drive low, index 0, waiting for enable
// DISCHARGE | drive low for DISCHARGE_CYCLES (counter counts down)
// CHARGE    | drive high, counter counts up until pad rises or TIMEOUT
// RECORD    | publish count/index, advance index
// SCAN_END  | debounce every pad at once, then restart or idle
module cap_sense_scanner #(
  parameter int NUM_SENSORS      = 9,
  parameter int DISCHARGE_CYCLES = 256,
  parameter int TIMEOUT          = 4095,
  parameter int THRESHOLD        = 400,
  parameter int DEBOUNCE         = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_SENSORS-1:0] capacitive_sensors_in,
  output logic                   capacitive_sensors_out,
  output logic [NUM_SENSORS-1:0] touched,
  output logic                   scan_done,
  output logic                   count_valid,
  output logic [15:0]            last_count,
  output logic [3:0]             last_index
);

  typedef enum logic [2:0] {IDLE, DISCHARGE, CHARGE, RECORD, SCAN_END} state_t;

  localparam logic [15:0] DIS_LOAD = 16'(DISCHARGE_CYCLES - 1);
  localparam logic [15:0] CNT_MAX  = 16'(TIMEOUT);
  localparam logic [15:0] CNT_THR  = 16'(THRESHOLD);
  localparam logic [3:0]  LAST_IDX = 4'(NUM_SENSORS - 1);
  localparam logic [2:0]  DEB_TC   = 3'(DEBOUNCE);

  state_t                 state, state_next;
  logic [NUM_SENSORS-1:0] sync_a, sync_b, raw;
  logic [15:0]            cnt;
  logic [3:0]             idx;
  logic [2:0]             agree_cnt [NUM_SENSORS];
  logic                   pad;
  logic                   charge_end;

  assign pad        = sync_b[idx];
  assign charge_end = pad || (cnt == CNT_MAX);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (enable) state_next = DISCHARGE;
      DISCHARGE: if (cnt == '0) state_next = CHARGE;
      CHARGE:    if (charge_end) state_next = RECORD;
      RECORD:    state_next = (idx == LAST_IDX) ? SCAN_END : DISCHARGE;
      SCAN_END:  state_next = enable ? DISCHARGE : IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    capacitive_sensors_out = (state == CHARGE);
    count_valid            = (state == RECORD);
    scan_done              = (state == SCAN_END);
  end

  // Discharge reuses the measurement counter as a down-counter, preloaded on every path into DISCHARGE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_a <= '0;
      sync_b <= '0;
      cnt    <= '0;
      idx    <= '0;
    end else begin
      sync_a <= capacitive_sensors_in;
      sync_b <= sync_a;
      case (state)
        IDLE: begin
          idx <= '0;
          cnt <= DIS_LOAD;
        end
        DISCHARGE: cnt <= (cnt == '0) ? '0 : cnt - 16'd1;
        CHARGE:    if (!charge_end) cnt <= cnt + 16'd1;
        RECORD: begin
          cnt <= DIS_LOAD;
          if (idx != LAST_IDX) idx <= idx + 4'd1;
        end
        SCAN_END: begin
          cnt <= DIS_LOAD;
          idx <= '0;
        end
        default: cnt <= DIS_LOAD;
      endcase
    end
  end

  // Latched on the CHARGE exit edge so the values are already stable while count_valid is high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_count <= '0;
      last_index <= '0;
      raw        <= '0;
    end else if (state == CHARGE && charge_end) begin
      last_count <= cnt;
      last_index <= idx;
      raw[idx]   <= (cnt >= CNT_THR);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      touched <= '0;
      for (int i = 0; i < NUM_SENSORS; i++) agree_cnt[i] <= '0;
    end else if (state == SCAN_END) begin
      for (int i = 0; i < NUM_SENSORS; i++) begin
        if (raw[i] != touched[i]) begin
          if (agree_cnt[i] + 3'd1 == DEB_TC) begin
            touched[i]   <= ~touched[i];
            agree_cnt[i] <= '0;
          end else begin
            agree_cnt[i] <= agree_cnt[i] + 3'd1;
          end
        end else begin
          agree_cnt[i] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cap_sense_scanner.sv
// Bench for cap_sense_scanner: pads modelled as RC delays after the drive pin rises,
// results compared against a scan-level model of counts, scan timing and debounced touch state.
module tb_cap_sense_scanner;
  localparam int N = 9, DIS = 4, TMO = 63, THR = 20, DEB = 2;

  logic         clock = 1'b0, reset = 1'b0, enable = 1'b0;
  logic [N-1:0] capacitive_sensors_in = '0;
  logic         capacitive_sensors_out, scan_done, count_valid;
  logic [N-1:0] touched;
  logic [15:0]  last_count;
  logic [3:0]   last_index;

  cap_sense_scanner #(.NUM_SENSORS(N), .DISCHARGE_CYCLES(DIS), .TIMEOUT(TMO),
                      .THRESHOLD(THR), .DEBOUNCE(DEB)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .capacitive_sensors_in(capacitive_sensors_in),
    .capacitive_sensors_out(capacitive_sensors_out),
    .touched(touched), .scan_done(scan_done), .count_valid(count_valid),
    .last_count(last_count), .last_index(last_index));

  always #5 clock = ~clock;

  int errors = 0, checks = 0;
  int dly [N];
  int obs_idx [16], obs_cnt [16], obs_chg [16];
  int obs_n, obs_sd, cyc = 0, last_sd_cyc = 0, prev_sd_cyc = 0, jc = 0, drop_idx = -1;
  bit both_seen, obs_out_hi;
  logic [N-1:0] m_tv = '0;
  logic [N-1:0] raw_hist [$];

  // A pad that rises d cycles into the charge is seen two cycles later, capped at TIMEOUT.
  function automatic int exp_count(input int d);
    return (d + 2 > TMO) ? TMO : d + 2;
  endfunction

  function automatic int exp_period();
    int p = 1;
    for (int i = 0; i < N; i++) p += DIS + exp_count(dly[i]) + 2;
    return p;
  endfunction

  // touched[i] flips once the last DEB scans all disagree with it.
  task automatic model_scan();
    logic [N-1:0] rv, h;
    bit flip;
    for (int i = 0; i < N; i++) rv[i] = (exp_count(dly[i]) >= THR);
    raw_hist.push_back(rv);
    for (int i = 0; i < N; i++) begin
      if (raw_hist.size() >= DEB) begin
        flip = 1;
        for (int k = 1; k <= DEB; k++) begin
          h = raw_hist[raw_hist.size() - k];
          if (h[i] == m_tv[i]) flip = 0;
        end
        if (flip) m_tv[i] = ~m_tv[i];
      end
    end
  endtask

  task automatic clear_obs();
    obs_n = 0; obs_sd = 0; both_seen = 0; obs_out_hi = 0;
  endtask

  task automatic step();
    @(posedge clock); #1;
    cyc++;
    if (count_valid) begin
      if (obs_n < 16) begin
        obs_idx[obs_n] = int'(last_index);
        obs_cnt[obs_n] = int'(last_count);
        obs_chg[obs_n] = jc;
      end
      obs_n++;
      if (int'(last_index) == drop_idx) begin enable = 1'b0; drop_idx = -1; end
    end
    if (scan_done) begin obs_sd++; prev_sd_cyc = last_sd_cyc; last_sd_cyc = cyc; end
    if (count_valid && scan_done) both_seen = 1;
    if (capacitive_sensors_out) begin
      obs_out_hi = 1;
      for (int i = 0; i < N; i++) capacitive_sensors_in[i] = (jc >= dly[i]);
      jc++;
    end else begin
      jc = 0;
      capacitive_sensors_in = '0;
    end
  endtask

  task automatic run_to_done();
    int guard = 0;
    int sd0 = obs_sd;
    while (obs_sd == sd0 && guard < 5000) begin step(); guard++; end
    if (obs_sd == sd0) begin
      checks++; errors++;
      $display("FAIL scan_watchdog: no scan_done within %0d cycles", guard);
    end
    step(); step();
  endtask

  task automatic scan();
    clear_obs();
    run_to_done();
    model_scan();
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    checks++; if (capacitive_sensors_out !== 1'b0) begin errors++; $display("FAIL reset_out: got %0b expected 0", capacitive_sensors_out); end
    checks++; if (touched !== '0) begin errors++; $display("FAIL reset_touched: got %h expected 0", touched); end
    checks++; if (scan_done !== 1'b0 || count_valid !== 1'b0) begin errors++; $display("FAIL reset_pulses: got sd=%0b cv=%0b expected 0 0", scan_done, count_valid); end
    checks++; if (last_count !== 16'd0 || last_index !== 4'd0) begin errors++; $display("FAIL reset_last: got cnt=%0d idx=%0d expected 0 0", last_count, last_index); end
    repeat (3) @(posedge clock);
    @(negedge clock) reset = 1'b0;
    clear_obs();
    repeat (10) step();
    checks++; if (obs_out_hi || obs_n != 0) begin errors++; $display("FAIL idle_quiet: got out_hi=%0b cv=%0d expected 0 0", obs_out_hi, obs_n); end
  endtask

  task automatic test_all_fast();
    int n = 0;
    for (int i = 0; i < N; i++) dly[i] = 5;
    clear_obs();
    enable = 1'b1;
    step();
    while (!capacitive_sensors_out && n < 50) begin n++; step(); end
    checks++; if (n != DIS) begin errors++; $display("FAIL start_latency: got %0d expected %0d", n, DIS); end
    run_to_done();
    model_scan();
    checks++; if (obs_n != N) begin errors++; $display("FAIL fast_cv_count: got %0d expected %0d", obs_n, N); end
    for (int j = 0; j < N; j++) begin
      checks++;
      if (obs_idx[j] != j || obs_cnt[j] != exp_count(dly[j]) || obs_chg[j] != exp_count(dly[j]) + 1) begin
        errors++;
        $display("FAIL fast_meas[%0d]: got idx=%0d cnt=%0d chg=%0d expected idx=%0d cnt=%0d chg=%0d",
                 j, obs_idx[j], obs_cnt[j], obs_chg[j], j, exp_count(dly[j]), exp_count(dly[j]) + 1);
      end
    end
    checks++; if (both_seen) begin errors++; $display("FAIL fast_overlap: got cv and scan_done together expected never"); end
    repeat (2) begin
      scan();
      checks++; if (last_sd_cyc - prev_sd_cyc != exp_period()) begin errors++; $display("FAIL fast_period: got %0d expected %0d", last_sd_cyc - prev_sd_cyc, exp_period()); end
    end
    checks++; if (touched !== m_tv || touched !== '0) begin errors++; $display("FAIL fast_touched: got %h expected %h", touched, m_tv); end
  endtask

  task automatic test_slow_sensor();
    for (int i = 0; i < N; i++) dly[i] = 0;
    dly[3] = 30;
    scan();
    checks++; if (obs_cnt[3] != exp_count(30)) begin errors++; $display("FAIL slow_count: got %0d expected %0d", obs_cnt[3], exp_count(30)); end
    checks++; if (touched !== m_tv) begin errors++; $display("FAIL slow_scan1: got %h expected %h", touched, m_tv); end
    scan();
    checks++; if (touched !== m_tv || touched !== 9'h008) begin errors++; $display("FAIL slow_scan2: got %h expected %h", touched, m_tv); end
  endtask

  task automatic test_release();
    dly[3] = 0;
    scan();
    checks++; if (touched[3] !== 1'b1 || touched !== m_tv) begin errors++; $display("FAIL release_scan1: got %h expected %h", touched, m_tv); end
    scan();
    checks++; if (touched[3] !== 1'b0 || touched !== m_tv) begin errors++; $display("FAIL release_scan2: got %h expected %h", touched, m_tv); end
  endtask

  task automatic test_glitch();
    dly[5] = 40;
    scan();
    dly[5] = 0;
    repeat (2) begin
      scan();
      checks++; if (touched[5] !== 1'b0 || touched !== m_tv) begin errors++; $display("FAIL glitch: got %h expected %h", touched, m_tv); end
    end
  endtask

  task automatic test_timeout();
    dly[8] = 1000;
    scan();
    checks++;
    if (obs_idx[8] != 8 || obs_cnt[8] != TMO || obs_chg[8] != TMO + 1) begin
      errors++;
      $display("FAIL timeout_meas: got idx=%0d cnt=%0d chg=%0d expected 8 %0d %0d", obs_idx[8], obs_cnt[8], obs_chg[8], TMO, TMO + 1);
    end
    scan();
    checks++; if (touched[8] !== 1'b1 || touched !== m_tv) begin errors++; $display("FAIL timeout_touch: got %h expected %h", touched, m_tv); end
    dly[8] = 0;
    scan(); scan();
    checks++; if (touched !== m_tv) begin errors++; $display("FAIL timeout_clear: got %h expected %h", touched, m_tv); end
  endtask

  task automatic test_threshold_edge();
    for (int i = 0; i < N; i++) dly[i] = (i % 2 == 1) ? THR - 2 : THR - 3;
    scan();
    for (int j = 0; j < N; j++) begin
      checks++; if (obs_cnt[j] != exp_count(dly[j])) begin errors++; $display("FAIL thr_count[%0d]: got %0d expected %0d", j, obs_cnt[j], exp_count(dly[j])); end
    end
    scan();
    checks++; if (touched !== m_tv) begin errors++; $display("FAIL thr_touched: got %h expected %h", touched, m_tv); end
    for (int i = 0; i < N; i++) dly[i] = 0;
    scan(); scan();
    checks++; if (touched !== m_tv) begin errors++; $display("FAIL thr_clear: got %h expected %h", touched, m_tv); end
  endtask

  task automatic test_random();
    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < N; i++) dly[i] = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 12) : $urandom_range(15, 70);
      scan();
      checks++; if (obs_n != N) begin errors++; $display("FAIL rnd_cv_count[%0d]: got %0d expected %0d", s, obs_n, N); end
      for (int j = 0; j < N; j++) begin
        checks++;
        if (obs_idx[j] != j || obs_cnt[j] != exp_count(dly[j]) || obs_chg[j] != exp_count(dly[j]) + 1) begin
          errors++;
          $display("FAIL rnd_meas[%0d][%0d]: got idx=%0d cnt=%0d chg=%0d expected idx=%0d cnt=%0d chg=%0d",
                   s, j, obs_idx[j], obs_cnt[j], obs_chg[j], j, exp_count(dly[j]), exp_count(dly[j]) + 1);
        end
      end
      checks++; if (last_sd_cyc - prev_sd_cyc != exp_period()) begin errors++; $display("FAIL rnd_period[%0d]: got %0d expected %0d", s, last_sd_cyc - prev_sd_cyc, exp_period()); end
      checks++; if (touched !== m_tv || both_seen) begin errors++; $display("FAIL rnd_touched[%0d]: got %h overlap=%0b expected %h overlap=0", s, touched, both_seen, m_tv); end
    end
  endtask

  task automatic test_enable_drop();
    for (int i = 0; i < N; i++) dly[i] = $urandom_range(0, 30);
    clear_obs();
    drop_idx = 4;
    run_to_done();
    model_scan();
    checks++; if (obs_n != N || obs_sd != 1) begin errors++; $display("FAIL drop_scan: got cv=%0d sd=%0d expected %0d 1", obs_n, obs_sd, N); end
    for (int j = 5; j < N; j++) begin
      checks++; if (obs_idx[j] != j || obs_cnt[j] != exp_count(dly[j])) begin errors++; $display("FAIL drop_meas[%0d]: got idx=%0d cnt=%0d expected %0d %0d", j, obs_idx[j], obs_cnt[j], j, exp_count(dly[j])); end
    end
    checks++; if (touched !== m_tv) begin errors++; $display("FAIL drop_touched: got %h expected %h", touched, m_tv); end
    clear_obs();
    repeat (40) step();
    checks++; if (obs_n != 0 || obs_sd != 0 || obs_out_hi) begin errors++; $display("FAIL drop_idle: got cv=%0d sd=%0d out_hi=%0b expected 0 0 0", obs_n, obs_sd, obs_out_hi); end
  endtask

  task automatic test_reset_mid_charge();
    int n = 0;
    int guard = 0;
    for (int i = 0; i < N; i++) dly[i] = 0;
    enable = 1'b1;
    scan(); scan();
    dly[3] = 30;
    scan(); scan();
    checks++; if (touched !== 9'h008 || touched !== m_tv) begin errors++; $display("FAIL pre_reset_touched: got %h expected %h", touched, m_tv); end
    clear_obs();
    step();
    while (!capacitive_sensors_out && guard < 100) begin guard++; step(); end
    #2 reset = 1'b1;
    #1;
    checks++; if (capacitive_sensors_out !== 1'b0) begin errors++; $display("FAIL async_out: got %0b expected 0", capacitive_sensors_out); end
    checks++; if (touched !== '0) begin errors++; $display("FAIL async_touched: got %h expected 0", touched); end
    checks++; if (count_valid !== 1'b0 || last_count !== 16'd0 || last_index !== 4'd0) begin errors++; $display("FAIL async_last: got cv=%0b cnt=%0d idx=%0d expected 0 0 0", count_valid, last_count, last_index); end
    m_tv = '0;
    raw_hist.delete();
    jc = 0;
    capacitive_sensors_in = '0;
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b0;
    clear_obs();
    step();
    while (!capacitive_sensors_out && n < 50) begin n++; step(); end
    checks++; if (n != DIS) begin errors++; $display("FAIL restart_latency: got %0d expected %0d", n, DIS); end
    run_to_done();
    model_scan();
    checks++; if (obs_n != N || obs_idx[0] != 0 || obs_cnt[0] != exp_count(dly[0])) begin errors++; $display("FAIL restart_scan: got cv=%0d idx0=%0d cnt0=%0d expected %0d 0 %0d", obs_n, obs_idx[0], obs_cnt[0], N, exp_count(dly[0])); end
    checks++; if (touched !== m_tv) begin errors++; $display("FAIL restart_touched: got %h expected %h", touched, m_tv); end
  endtask

  initial begin
    for (int i = 0; i < N; i++) dly[i] = 0;
    test_reset();
    test_all_fast();
    test_slow_sensor();
    test_release();
    test_glitch();
    test_timeout();
    test_threshold_edge();
    test_random();
    test_enable_drop();
    test_reset_mid_charge();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cap_sense_scanner.md
# cap_sense_scanner

Time-multiplexed capacitive touch scanner for the whack-a-mole pad array. It shares one charge/discharge drive pin and one cycle counter among `NUM_SENSORS` sense inputs, scanning them in round-robin order. For each sensor it measures the RC rise time and debounces the touch decision across scans. It sits between the board pins (`capacitive_sensors_in` / `capacitive_sensors_out`) and the processor's memory-mapped I/O, which reads `touched`.

## Interface
- `NUM_SENSORS`, 9: number of sense inputs (1..16).
- `DISCHARGE_CYCLES`, 256: cycles the drive pin is held low before each measurement (≥1).
- `TIMEOUT`, 4095: maximum charge count; a measurement is forced to end at this value.
- `THRESHOLD`, 400: a count ≥ THRESHOLD is a raw touch.
- `DEBOUNCE`, 2: consecutive disagreeing scans required to flip `touched[i]` (1..7).
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `enable`  in  1  level; high starts or continues scanning.
- `capacitive_sensors_in`  in  NUM_SENSORS  raw pad inputs; asynchronous to `clock`.
- `capacitive_sensors_out`  out  1  shared drive pin: 0 = discharge, 1 = charge.
- `touched`  out  NUM_SENSORS  debounced touch state, bit i = sensor i.
- `scan_done`  out  1  one-cycle pulse when a full scan completes.
- `count_valid`  out  1  one-cycle pulse when `last_count`/`last_index` are updated.
- `last_count`  out  16  rise-time count of the most recent measurement.
- `last_index`  out  4  sensor index of the most recent measurement.

## Operation
- Each input goes through a 2-flop synchronizer; all decisions use the synchronized bit `s[i]`.
- FSM states: IDLE, DISCHARGE, CHARGE, RECORD, SCAN_END.
- IDLE: out=0, idx=0. If `enable`=1, go to DISCHARGE.
- DISCHARGE: out=0. Counter cleared on entry. After exactly `DISCHARGE_CYCLES` cycles in this state, go to CHARGE with the counter cleared.
- CHARGE: out=1. Each cycle: if `s[idx]`=1, go to RECORD holding the counter; else if counter == TIMEOUT, go to RECORD; else counter+1.
- RECORD: one cycle. `last_count` = counter (zero-extended; TIMEOUT saturates), `last_index` = idx, `count_valid`=1, `raw[idx]` = (counter ≥ THRESHOLD). If idx == NUM_SENSORS-1, go to SCAN_END; else idx+1 and go to DISCHARGE.
- SCAN_END: one cycle, `scan_done`=1, and all sensors are updated at once:
  - if `raw[i]` ≠ `touched[i]`: `agree_cnt[i]`+1; when it reaches DEBOUNCE, toggle `touched[i]` and clear `agree_cnt[i]`;
  - else clear `agree_cnt[i]`.
  - Next state: DISCHARGE with idx=0 if `enable`=1, else IDLE.
- `enable` deasserted mid-scan: the current scan completes, including the SCAN_END debounce update, and the FSM then enters IDLE. No partial-scan update of `touched` ever happens.
- `touched` changes only in SCAN_END and therefore always reflects whole scans.

## Timing
- Reset values: out=0, `touched`=0, `scan_done`=0, `count_valid`=0, `last_count`=0, `last_index`=0. State=IDLE, idx=0, all `raw`, `agree_cnt` and synchronizer flops=0.
- Reset asserted in any state, including mid-CHARGE: outputs take their reset values immediately (asynchronously), without waiting for a clock edge.
- Start latency: `enable` sampled high in IDLE gives out=0 for DISCHARGE_CYCLES cycles, then out=1.
- A pad that rises k cycles after the first CHARGE cycle is recorded as count = k+2 (synchronizer latency). A pad already high at CHARGE entry yields count ≤ 2.
- Per-sensor time = DISCHARGE_CYCLES + (count+1) + 1 cycles.
- Per-scan time = sum of per-sensor times + 1 (SCAN_END).
- `count_valid` fires NUM_SENSORS times per scan, and `scan_done` fires once per scan, one cycle after the last `count_valid`. The two never assert in the same cycle.

## Test plan
- Params DISCHARGE_CYCLES=4, TIMEOUT=63, THRESHOLD=20, DEBOUNCE=2; all pads rise 5 cycles after out rises:
  - required: 9 `count_valid` pulses per scan, each with `last_count`=7, `last_index` 0..8 in order;
  - required: `touched`=0 after 3 scans.
- Sensor 3 rises 30 cycles after charge start (count 32), all others fast:
  - required: `touched`=9'b000001000 at the 2nd `scan_done`, not at the 1st.
- Sensor 8 never rises:
  - required: `last_count`=63 for index 8, CHARGE lasts exactly 64 cycles;
  - required: `touched[8]`=1 after 2 scans.
- Sensor 3 touched for 2 scans, then released:
  - required: `touched[3]` stays 1 after the 1st release scan and clears at the 2nd.
  - A single-scan glitch (touch on one scan only) never sets `touched`.
- Deassert `enable` while idx=4:
  - required: indexes 5..8 are still measured, `scan_done` pulses once, then IDLE with out=0 and no further `count_valid`.
- Assert `reset` mid-CHARGE with `touched`=9'h008:
  - required: out=0 and `touched`=0 immediately, before the next clock edge;
  - required: after release with `enable`=1, scanning restarts at index 0 after 4 DISCHARGE cycles.
